byte_stream_ram_packer: RTL and testbench

//  Write-side front end for the single-port block RAM with per-byte write enables.

---
 rtl/byte_stream_ram_packer.sv | 123 ++++++++++++
 tb/tb_byte_stream_ram_packer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/byte_stream_ram_packer.sv
// Packs a valid/ready byte stream into 2-lane words and drives a byte-enabled
// single-port RAM write port, with flush, address load and wrap/full handling.
module byte_stream_ram_packer #(
  parameter int SIZE      = 512,
  parameter int ADD_WIDTH = 9,
  parameter int DI_WIDTH  = 8,
  parameter int WRAP      = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DI_WIDTH-1:0]   byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  flush,
  input  logic                  addr_load,
  input  logic [ADD_WIDTH-1:0]  addr_load_val,
  output logic [1:0]            ram_we,
  output logic [ADD_WIDTH-1:0]  ram_addr,
  output logic [2*DI_WIDTH-1:0] ram_di,
  output logic                  full,
  output logic                  wrap_pulse
);

  typedef enum logic [1:0] {EMPTY, HALF, STOP} state_t;

  localparam logic [ADD_WIDTH-1:0] LAST = ADD_WIDTH'(SIZE - 1);

  state_t                state_q, state_d;
  logic [DI_WIDTH-1:0]   held_q, held_d;
  logic [ADD_WIDTH-1:0]  next_addr_q, next_addr_d;
  logic [1:0]            ram_we_q, ram_we_d;
  logic [ADD_WIDTH-1:0]  ram_addr_q, ram_addr_d;
  logic [2*DI_WIDTH-1:0] ram_di_q, ram_di_d;
  logic                  full_q, full_d;
  logic                  wrap_pulse_q, wrap_pulse_d;

  logic                  accept;
  logic [1:0]            wr_we;
  logic [2*DI_WIDTH-1:0] wr_di;

  assign byte_ready = RST_N & ~addr_load & (state_q != STOP);
  assign accept     = byte_valid & byte_ready;

  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    next_addr_d  = next_addr_q;
    ram_we_d     = 2'b00;
    ram_addr_d   = ram_addr_q;
    ram_di_d     = ram_di_q;
    full_d       = full_q;
    wrap_pulse_d = 1'b0;
    wr_we        = 2'b00;
    wr_di        = '0;
    if (addr_load) begin
      next_addr_d = addr_load_val;
      state_d     = EMPTY;
      full_d      = 1'b0;
    end else begin
      // Flush is resolved against the state after this cycle's accept.
      if (accept && state_q == HALF) begin
        wr_we = 2'b11;
        wr_di = {byte_in, held_q};
      end else if (accept) begin
        held_d = byte_in;
        if (flush) begin
          wr_we = 2'b01;
          wr_di = {{DI_WIDTH{1'b0}}, byte_in};
        end else begin
          state_d = HALF;
        end
      end else if (flush && state_q == HALF) begin
        wr_we = 2'b01;
        wr_di = {{DI_WIDTH{1'b0}}, held_q};
      end
      if (wr_we != 2'b00) begin
        ram_we_d    = wr_we;
        ram_addr_d  = next_addr_q;
        ram_di_d    = wr_di;
        state_d     = EMPTY;
        next_addr_d = next_addr_q + ADD_WIDTH'(1);
        if (next_addr_q == LAST) begin
          next_addr_d = '0;
          if (WRAP != 0) begin
            wrap_pulse_d = 1'b1;
          end else begin
            full_d  = 1'b1;
            state_d = STOP;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= EMPTY;
      held_q       <= '0;
      next_addr_q  <= '0;
      ram_we_q     <= 2'b00;
      ram_addr_q   <= '0;
      ram_di_q     <= '0;
      full_q       <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      next_addr_q  <= next_addr_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_di_q     <= ram_di_d;
      full_q       <= full_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_di     = ram_di_q;
  assign full       = full_q;
  assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_byte_stream_ram_packer.sv
// Directed table-driven bench: a wrapping packer and a stopping packer share stimulus.
module tb_byte_stream_ram_packer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  byte_in;
  logic        byte_valid, flush, addr_load;
  logic [8:0]  addr_load_val;

  logic        rdy, rdy0;
  logic [1:0]  we, we0;
  logic [8:0]  addr, addr0;
  logic [15:0] di, di0;
  logic        full, full0, wrap, wrap0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  byte_stream_ram_packer #(.SIZE(512), .ADD_WIDTH(9), .DI_WIDTH(8), .WRAP(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy), .flush(flush), .addr_load(addr_load), .addr_load_val(addr_load_val),
    .ram_we(we), .ram_addr(addr), .ram_di(di), .full(full), .wrap_pulse(wrap));

  byte_stream_ram_packer #(.SIZE(512), .ADD_WIDTH(9), .DI_WIDTH(8), .WRAP(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy0), .flush(flush), .addr_load(addr_load), .addr_load_val(addr_load_val),
    .ram_we(we0), .ram_addr(addr0), .ram_di(di0), .full(full0), .wrap_pulse(wrap0));

  typedef struct {
    logic        rst_n;
    logic        v;
    logic [7:0]  b;
    logic        fl;
    logic        ld;
    logic [8:0]  lv;
    logic        rdy;
    logic        rdy0;
    logic [1:0]  we;
    logic        chk_ad;
    logic [8:0]  addr;
    logic [15:0] di;
    logic        wrap;
    logic        full0;
  } vec_t;

  localparam int NV = 25;
  vec_t tv[NV];

  function automatic vec_t mk(logic rst_n, logic v, logic [7:0] b, logic fl, logic ld,
                              logic [8:0] lv, logic r, logic r0, logic [1:0] w, logic ca,
                              logic [8:0] a, logic [15:0] d, logic wp, logic f0);
    vec_t t;
    t.rst_n = rst_n; t.v = v; t.b = b; t.fl = fl; t.ld = ld; t.lv = lv;
    t.rdy = r; t.rdy0 = r0; t.we = w; t.chk_ad = ca; t.addr = a; t.di = d;
    t.wrap = wp; t.full0 = f0;
    return t;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic rst_n, logic v, logic [7:0] b, logic fl, logic ld, logic [8:0] lv);
    @(negedge CLK);
    RST_N = rst_n; byte_valid = v; byte_in = b; flush = fl; addr_load = ld; addr_load_val = lv;
    #1;
  endtask

  task automatic settle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; byte_valid = 1'b0; byte_in = '0; flush = 1'b0;
    addr_load = 1'b0; addr_load_val = '0;

    //          rst v  byte   fl ld lv    rdy r0 we     ca addr  di        wp f0
    tv[0]  = mk(0, 0, 8'h00, 0, 0, 9'd0,   0, 0, 2'b00, 1, 9'd0,   16'h0000, 0, 0);
    tv[1]  = mk(1, 1, 8'h11, 0, 0, 9'd0,   1, 1, 2'b00, 1, 9'd0,   16'h0000, 0, 0);
    tv[2]  = mk(1, 1, 8'h22, 0, 0, 9'd0,   1, 1, 2'b11, 1, 9'd0,   16'h2211, 0, 0);
    tv[3]  = mk(1, 1, 8'h33, 0, 0, 9'd0,   1, 1, 2'b00, 0, 9'd0,   16'h0000, 0, 0);
    tv[4]  = mk(1, 0, 8'h00, 1, 0, 9'd0,   1, 1, 2'b01, 1, 9'd1,   16'h0033, 0, 0);
    tv[5]  = mk(1, 1, 8'h44, 0, 0, 9'd0,   1, 1, 2'b00, 0, 9'd0,   16'h0000, 0, 0);
    tv[6]  = mk(1, 1, 8'h55, 0, 0, 9'd0,   1, 1, 2'b11, 1, 9'd2,   16'h5544, 0, 0);
    tv[7]  = mk(1, 1, 8'h66, 0, 0, 9'd0,   1, 1, 2'b00, 0, 9'd0,   16'h0000, 0, 0);
    tv[8]  = mk(1, 1, 8'hAA, 1, 0, 9'd0,   1, 1, 2'b11, 1, 9'd3,   16'hAA66, 0, 0);
    tv[9]  = mk(1, 0, 8'h00, 0, 0, 9'd0,   1, 1, 2'b00, 1, 9'd3,   16'hAA66, 0, 0);
    tv[10] = mk(1, 1, 8'h77, 1, 0, 9'd0,   1, 1, 2'b01, 1, 9'd4,   16'h0077, 0, 0);
    tv[11] = mk(1, 1, 8'h88, 0, 0, 9'd0,   1, 1, 2'b00, 0, 9'd0,   16'h0000, 0, 0);
    tv[12] = mk(1, 1, 8'h99, 1, 1, 9'd100, 0, 0, 2'b00, 1, 9'd4,   16'h0077, 0, 0);
    tv[13] = mk(1, 1, 8'h01, 0, 0, 9'd0,   1, 1, 2'b00, 0, 9'd0,   16'h0000, 0, 0);
    tv[14] = mk(1, 1, 8'h02, 0, 0, 9'd0,   1, 1, 2'b11, 1, 9'd100, 16'h0201, 0, 0);
    tv[15] = mk(1, 0, 8'h00, 1, 0, 9'd0,   1, 1, 2'b00, 0, 9'd0,   16'h0000, 0, 0);
    tv[16] = mk(1, 0, 8'h00, 0, 1, 9'd511, 0, 0, 2'b00, 0, 9'd0,   16'h0000, 0, 0);
    tv[17] = mk(1, 1, 8'h10, 0, 0, 9'd0,   1, 1, 2'b00, 0, 9'd0,   16'h0000, 0, 0);
    tv[18] = mk(1, 1, 8'h20, 0, 0, 9'd0,   1, 1, 2'b11, 1, 9'd511, 16'h2010, 1, 1);
    tv[19] = mk(1, 1, 8'h30, 0, 0, 9'd0,   1, 0, 2'b00, 0, 9'd0,   16'h0000, 0, 1);
    tv[20] = mk(1, 1, 8'h40, 0, 0, 9'd0,   1, 0, 2'b11, 1, 9'd0,   16'h4030, 0, 1);
    tv[21] = mk(1, 1, 8'h50, 0, 0, 9'd0,   1, 0, 2'b00, 0, 9'd0,   16'h0000, 0, 1);
    tv[22] = mk(0, 1, 8'h60, 0, 0, 9'd0,   0, 0, 2'b00, 1, 9'd0,   16'h0000, 0, 0);
    tv[23] = mk(1, 1, 8'h61, 0, 0, 9'd0,   1, 1, 2'b00, 0, 9'd0,   16'h0000, 0, 0);
    tv[24] = mk(1, 1, 8'h62, 0, 0, 9'd0,   1, 1, 2'b11, 1, 9'd0,   16'h6261, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].rst_n, tv[i].v, tv[i].b, tv[i].fl, tv[i].ld, tv[i].lv);
      chk($sformatf("v%0d byte_ready", i), int'(rdy), int'(tv[i].rdy));
      chk($sformatf("v%0d byte_ready_nowrap", i), int'(rdy0), int'(tv[i].rdy0));
      settle();
      chk($sformatf("v%0d ram_we", i), int'(we), int'(tv[i].we));
      chk($sformatf("v%0d wrap_pulse", i), int'(wrap), int'(tv[i].wrap));
      chk($sformatf("v%0d full_nowrap", i), int'(full0), int'(tv[i].full0));
      chk($sformatf("v%0d full_wrap", i), int'(full), 0);
      if (tv[i].chk_ad) begin
        chk($sformatf("v%0d ram_addr", i), int'(addr), int'(tv[i].addr));
        chk($sformatf("v%0d ram_di", i), int'(di), int'(tv[i].di));
      end
    end

    // Stopping packer: fill last address, stay blocked, then reload address 5.
    drive(1, 0, 8'h00, 0, 1, 9'd511);
    settle();
    drive(1, 1, 8'hC1, 0, 0, 9'd0);
    settle();
    drive(1, 1, 8'hC2, 0, 0, 9'd0);
    settle();
    chk("stop we", int'(we0), 2'b11);
    chk("stop addr", int'(addr0), 511);
    chk("stop di", int'(di0), 16'hC2C1);
    chk("stop no wrap_pulse", int'(wrap0), 0);
    chk("stop full", int'(full0), 1);
    drive(1, 1, 8'hC3, 1, 0, 9'd0);
    chk("stop ready low", int'(rdy0), 0);
    settle();
    chk("stop no write", int'(we0), 0);
    chk("stop full held", int'(full0), 1);
    drive(1, 1, 8'hC4, 0, 1, 9'd5);
    settle();
    chk("reload full clr", int'(full0), 0);
    chk("reload no write", int'(we0), 0);
    drive(1, 1, 8'hAB, 0, 0, 9'd0);
    chk("reload ready", int'(rdy0), 1);
    settle();
    drive(1, 1, 8'hCD, 0, 0, 9'd0);
    settle();
    chk("reload we", int'(we0), 2'b11);
    chk("reload addr", int'(addr0), 5);
    chk("reload di", int'(di0), 16'hCDAB);
    drive(1, 0, 8'h00, 0, 0, 9'd0);
    settle();
    chk("pulse single", int'(we0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
